veerwolf_irq_arbiter: RTL

//  Shares one core interrupt line between N_SRC peripheral IRQ sources (GPIO, PTC, UART, SPI...).

---
 rtl/veerwolf_irq_pkg.sv | 39 +++
 rtl/veerwolf_irq_arbiter_if.sv | 14 +
 rtl/veerwolf_irq_arbiter_rr_picker.sv | 32 +++
 rtl/veerwolf_irq_arbiter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/veerwolf_irq_pkg.sv
// Shared types and constants for the veerwolf interrupt arbiter.
// Register offsets are word indices taken from adr[5:2].
package veerwolf_irq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    ASSERT,
    SERVICE
  } state_t;

  localparam int unsigned ID_W = 5;

  localparam logic [3:0] REG_PENDING = 4'd0;
  localparam logic [3:0] REG_ENABLE  = 4'd1;
  localparam logic [3:0] REG_CLAIM   = 4'd2;
  localparam logic [3:0] REG_STATUS  = 4'd3;
  localparam logic [3:0] REG_EDGE    = 4'd4;

  localparam logic [ID_W-1:0] ID_NONE = 5'd0;

  // Bus-visible tag for a source: id+1, so that 0 can mean "none".
  function automatic logic [ID_W-1:0] id_tag(input logic [ID_W-1:0] id);
    return id + 5'd1;
  endfunction

  // Byte-lane merge of a write into an existing 32-bit register image.
  function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                             input logic [31:0] dat,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old;
    for (int unsigned b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = dat[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/veerwolf_irq_arbiter_if.sv
// Wishbone slave bus bundle for the interrupt arbiter.
interface veerwolf_irq_arbiter_if;
  logic [5:0]  adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [31:0] rdt;
  logic        ack;

  modport master (output adr, dat, sel, we, cyc, stb, input rdt, ack);
  modport slave  (input adr, dat, sel, we, cyc, stb, output rdt, ack);
endinterface

// File: rtl/veerwolf_irq_arbiter_rr_picker.sv
// Combinational round-robin find-first: lowest set bit of req at or after ptr, wrapping.
module irq_rr_picker #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 5
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] id
);
  localparam int unsigned SW = W + 1;

  logic [N-1:0]  rot;
  logic [SW-1:0] sum;

  // Rotate so that bit 0 of rot corresponds to source ptr.
  assign rot = N'({req, req} >> ptr);

  always_comb begin
    valid = 1'b0;
    id    = '0;
    sum   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!valid && rot[k]) begin
        valid = 1'b1;
        sum   = SW'(ptr) + SW'(k);
        if (sum >= SW'(N)) sum = sum - SW'(N);
        id    = sum[W-1:0];
      end
    end
  end
endmodule

// File: rtl/veerwolf_irq_arbiter.sv
// Round-robin interrupt arbiter with Wishbone claim/complete handshake.
// Define IRQ_ARB_EDGE_DET_EN to add per-source rising-edge capture (register 0x10).
module veerwolf_irq_arbiter
  import veerwolf_irq_pkg::*;
#(
  parameter int unsigned N_SRC = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_SRC-1:0]      i_src,
  veerwolf_irq_arbiter_if.slave wb,
  output logic                  o_irq
);

  state_t            state, state_nxt;
  logic [N_SRC-1:0]  pending, enable, edge_sel, masked, grant_oh;
  logic [ID_W-1:0]   grant_id, rr_ptr, insvc_tag, pick_id, ptr_nxt;
  logic              pick_valid, live;
  logic              acc, rd, wr, claim_rd, complete;
  logic [3:0]        reg_idx;
  logic [31:0]       rd_data, enable_w;
  logic              unused_bits;

  assign acc      = wb.cyc & wb.stb & ~wb.ack;
  assign rd       = acc & ~wb.we;
  assign wr       = acc & wb.we;
  assign reg_idx  = wb.adr[5:2];
  assign masked   = pending & enable;
  assign grant_oh = {{(N_SRC-1){1'b0}}, 1'b1} << grant_id;

  // Claims outside ASSERT are plain zero reads with no side effect.
  assign claim_rd = rd && (reg_idx == REG_CLAIM) && (state == ASSERT);
  assign complete = wr && (reg_idx == REG_CLAIM) && (state == SERVICE) &&
                    (wb.dat == {27'b0, insvc_tag});

  // Edge sources stay live in ASSERT until claimed or masked.
  assign live = |(grant_oh & enable & (pending | edge_sel));

  assign enable_w = byte_merge(32'(enable), wb.dat, wb.sel);
  assign ptr_nxt  = (id_tag(grant_id) == ID_W'(N_SRC)) ? ID_NONE : id_tag(grant_id);

  irq_rr_picker #(.N(N_SRC), .W(ID_W)) u_picker (
    .req   (masked),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .id    (pick_id)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|masked) state_nxt = ARB;
      ARB:     state_nxt = pick_valid ? ASSERT : IDLE;
      ASSERT: begin
        if (claim_rd)   state_nxt = SERVICE;
        else if (!live) state_nxt = IDLE;
      end
      SERVICE: if (complete) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      o_irq     <= 1'b0;
      grant_id  <= ID_NONE;
      rr_ptr    <= ID_NONE;
      insvc_tag <= ID_NONE;
      enable    <= '0;
    end else begin
      state <= state_nxt;
      o_irq <= (state_nxt == ASSERT);
      if (state == ARB && pick_valid) grant_id <= pick_id;
      if (claim_rd) begin
        insvc_tag <= id_tag(grant_id);
        rr_ptr    <= ptr_nxt;
      end
      if (complete) insvc_tag <= ID_NONE;
      if (wr && reg_idx == REG_ENABLE) enable <= enable_w[N_SRC-1:0];
    end
  end

`ifdef IRQ_ARB_EDGE_DET_EN
  logic [N_SRC-1:0] src_q, rise, clr;
  logic [31:0]      edge_w, w1c_w;

  assign edge_w = byte_merge(32'(edge_sel), wb.dat, wb.sel);
  assign w1c_w  = byte_merge('0, wb.dat, wb.sel);
  assign rise   = i_src & ~src_q;
  assign clr    = ((wr && reg_idx == REG_PENDING) ? w1c_w[N_SRC-1:0] : '0) |
                  (claim_rd ? grant_oh : '0);

  // Edge bits are sticky; a same-cycle rise beats any clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      src_q    <= '0;
      edge_sel <= '0;
      pending  <= '0;
    end else begin
      src_q   <= i_src;
      pending <= (~edge_sel & i_src) | (edge_sel & ((pending & ~clr) | rise));
      if (wr && reg_idx == REG_EDGE) edge_sel <= edge_w[N_SRC-1:0];
    end
  end

  assign unused_bits = &{1'b0, wb.adr[1:0], enable_w[31:N_SRC], edge_w[31:N_SRC],
                         w1c_w[31:N_SRC]};
`else
  assign edge_sel = '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) pending <= '0;
    else       pending <= i_src;
  end

  assign unused_bits = &{1'b0, wb.adr[1:0], enable_w[31:N_SRC]};
`endif

  always_comb begin
    rd_data = '0;
    case (reg_idx)
      REG_PENDING: rd_data = 32'(pending);
      REG_ENABLE:  rd_data = 32'(enable);
      REG_CLAIM:   rd_data = (state == ASSERT) ? {27'b0, id_tag(grant_id)} : '0;
      REG_STATUS:  rd_data = {(state == SERVICE), 26'b0, insvc_tag};
`ifdef IRQ_ARB_EDGE_DET_EN
      REG_EDGE:    rd_data = 32'(edge_sel);
`endif
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wb.ack <= 1'b0;
      wb.rdt <= '0;
    end else begin
      wb.ack <= wb.cyc & ~wb.ack;
      wb.rdt <= rd ? rd_data : '0;
    end
  end

endmodule
